fft_frame_ctrl: RTL and testbench
=================================

FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

Interface
REQ-001 SHALL have parameter LOG2_FFT_LEN, default 11, meaning log2 of the transform length N (N = 2048).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning the width of the packed {im,re} sample word on the FFT data input.
REQ-003 SHALL have parameter TIMEOUT, default 65535, meaning the maximum number of enabled cycles allowed in WAIT_OUT.
REQ-004 SHALL have port i_aclk, input, 1, the single clock; all logic is rising-edge.
REQ-005 SHALL have port i_aresetn, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have port i_aclken, input, 1, clock enable; low freezes all state and registered outputs.
REQ-007 SHALL have port i_start, input, 1, frame request pulse.
REQ-008 SHALL have port i_inv, input, 1, direction sampled with i_start; 1 = inverse, 0 = forward.
REQ-009 SHALL have port o_busy, output, 1, high whenever state is not IDLE.
REQ-010 SHALL have port o_done, output, 1, one-cycle pulse when a frame completes.
REQ-011 SHALL have port o_err, output, 1, one-cycle pulse when WAIT_OUT times out.
REQ-012 SHALL have ports i_src_tvalid (input, 1), i_src_tdata (input, DATA_WIDTH) and o_src_tready (output, 1), the sample source AXI4-Stream.
REQ-013 SHALL have ports o_fft_cfg_tvalid (output, 1) and o_fft_cfg_tdata (output, 8), the FFT config channel; bit0 = inverse, bits7:1 = 0.
REQ-014 SHALL have ports o_fft_data_tvalid (output, 1), o_fft_data_tdata (output, DATA_WIDTH), o_fft_data_tlast (output, 1) and i_fft_data_tready (input, 1), the FFT input stream.
REQ-015 SHALL have ports i_fft_out_tvalid (input, 1), i_fft_out_tlast (input, 1) and i_fft_alm (input, 3), the FFT output observation inputs.
REQ-016 SHALL have ports o_frame_cnt (output, 16), count of completed frames, and o_alm_sticky (output, 3), OR of i_fft_alm since the last accepted start.

Function
REQ-017 SHALL implement the states IDLE, CFG, LOAD, WAIT_OUT and DONE; every transition is qualified by i_aclken=1.
REQ-018 SHALL, in IDLE with i_start=1: latch i_inv, clear o_alm_sticky, and move to CFG.
REQ-019 SHALL ignore i_start in every state other than IDLE; no queuing.
REQ-020 SHALL, in CFG, assert o_fft_cfg_tvalid for exactly one cycle with bit0 = the latched i_inv, then move to LOAD; the config channel has no tready.
REQ-021 SHALL, in LOAD, drive o_fft_data_tvalid = i_src_tvalid, o_src_tready = i_fft_data_tready and o_fft_data_tdata = i_src_tdata combinationally; outside LOAD, o_src_tready=0 and o_fft_data_tvalid=0.
REQ-022 SHALL use an LOG2_FFT_LEN-bit sample counter, cleared on entry to LOAD and incremented only on a source handshake (tvalid & tready).
REQ-023 SHALL assert o_fft_data_tlast only while the sample counter = N-1; the handshake at N-1 moves to WAIT_OUT, and the counter wraps to 0.
REQ-024 SHALL make source backpressure or stalls of any length in LOAD add no samples and lose no samples.
REQ-025 SHALL, in WAIT_OUT, move to DONE on i_fft_out_tvalid & i_fft_out_tlast.
REQ-026 SHALL count enabled cycles in WAIT_OUT with a watchdog; on reaching TIMEOUT with no output tlast, pulse o_err and return to IDLE without incrementing o_frame_cnt.
REQ-027 SHALL, if output tlast and the timeout coincide in the same cycle, give the tlast priority (DONE, no o_err).
REQ-028 SHALL, in DONE, pulse o_done for one cycle, increment o_frame_cnt (wrapping 0xFFFF to 0), and return to IDLE.
REQ-029 SHALL OR i_fft_alm into o_alm_sticky in every non-IDLE cycle; when set on the same cycle as the clear of REQ-018, the clear wins.
REQ-030 SHALL give a latency of 1 cycle from i_start to o_fft_cfg_tvalid and 1 cycle from output tlast to o_done.

Reset
REQ-031 SHALL, on i_aresetn low, put state to IDLE and set o_busy, o_done, o_err, o_fft_cfg_tvalid, o_fft_cfg_tdata, o_frame_cnt, o_alm_sticky, the sample counter and the watchdog to 0, taking effect immediately.
REQ-032 SHALL, on reset mid-frame, abandon the frame with no o_done or o_err; a resync of the FFT core is handled by the core's own reset.

Structure
REQ-033 SHALL place the state encoding, the config bit position and the default N in the shared fft_ctrl_pkg package.
REQ-034 SHALL be a single module; the watchdog may be the sub-module fft_ctrl_wdog.

Verification
REQ-035 SHALL cover: start with inv=1 and continuous source/tready -> cfg_tvalid with tdata=0x01 at cycle 1, 2048 handshakes, tlast only on the 2048th; output tlast -> o_done one cycle later, frame_cnt=1.
REQ-036 SHALL cover: random tvalid/tready gaps at 50% -> exactly 2048 handshakes, data order preserved, tlast on the last one.
REQ-037 SHALL cover: i_start pulses during LOAD -> ignored; exactly one cfg pulse per frame.
REQ-038 SHALL cover: no output tlast with TIMEOUT=100 -> o_err pulse after 100 enabled WAIT_OUT cycles, state IDLE, frame_cnt unchanged.
REQ-039 SHALL cover: i_fft_alm=3'b010 for one cycle in LOAD -> o_alm_sticky=3'b010 until the next accepted start, then 0.
REQ-040 SHALL cover: i_aresetn low at sample 1000, then start -> full 2048-sample frame from counter 0; i_aclken low for 10 cycles mid-LOAD -> no state change.

Source files
------------

// File: rtl/fft_ctrl_pkg.sv
// Shared definitions for the FFT frame controller.
// State encoding, config word layout and default transform size.
package fft_ctrl_pkg;

    localparam int DEF_LOG2_FFT_LEN = 11;
    localparam int CFG_INV_BIT      = 0;
    localparam int CFG_WIDTH        = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CFG      = 3'd1,
        LOAD     = 3'd2,
        WAIT_OUT = 3'd3,
        DONE     = 3'd4
    } state_t;

endpackage

// File: rtl/fft_ctrl_wdog.sv
// WAIT_OUT watchdog: counts enabled cycles while armed.
// o_expire marks the TIMEOUT-th enabled cycle of a run.
module fft_ctrl_wdog #(
    parameter int TIMEOUT = 65535
) (
    input  logic i_aclk,
    input  logic i_aresetn,
    input  logic i_aclken,
    input  logic i_run,
    output logic o_expire
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt_q;

    assign o_expire = i_run & (cnt_q == LAST);

    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            cnt_q <= '0;
        end else if (i_aclken) begin
            if (!i_run || o_expire) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + ONE;
            end
        end
    end

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame controller for a streaming FFT core: config, load,
// wait for output tlast, with watchdog and alarm capture.
module fft_frame_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int LOG2_FFT_LEN = DEF_LOG2_FFT_LEN,
    parameter int DATA_WIDTH   = 32,
    parameter int TIMEOUT      = 65535
) (
    input  logic                  i_aclk,
    input  logic                  i_aresetn,
    input  logic                  i_aclken,
    input  logic                  i_start,
    input  logic                  i_inv,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    input  logic                  i_src_tvalid,
    input  logic [DATA_WIDTH-1:0] i_src_tdata,
    output logic                  o_src_tready,
    output logic                  o_fft_cfg_tvalid,
    output logic [CFG_WIDTH-1:0]  o_fft_cfg_tdata,
    output logic                  o_fft_data_tvalid,
    output logic [DATA_WIDTH-1:0] o_fft_data_tdata,
    output logic                  o_fft_data_tlast,
    input  logic                  i_fft_data_tready,
    input  logic                  i_fft_out_tvalid,
    input  logic                  i_fft_out_tlast,
    input  logic [2:0]            i_fft_alm,
    output logic [15:0]           o_frame_cnt,
    output logic [2:0]            o_alm_sticky
);

    localparam logic [LOG2_FFT_LEN-1:0] LAST_IDX = '1;
    localparam logic [LOG2_FFT_LEN-1:0] SMP_ONE  = LOG2_FFT_LEN'(1);

    state_t                  state_q;
    state_t                  state_d;
    logic [LOG2_FFT_LEN-1:0] smp_cnt_q;
    logic [CFG_WIDTH-1:0]    cfg_word;
    logic                    in_load;
    logic                    in_wait;
    logic                    src_hs;
    logic                    last_smp;
    logic                    out_last;
    logic                    wd_expire;
    logic                    accept;

    assign in_load  = (state_q == LOAD);
    assign in_wait  = (state_q == WAIT_OUT);
    assign accept   = (state_q == IDLE) & i_start;
    assign out_last = i_fft_out_tvalid & i_fft_out_tlast;
    assign last_smp = (smp_cnt_q == LAST_IDX);

    // Handshake gated by the enable so a frozen counter never misses a beat.
    assign o_src_tready      = in_load & i_aclken & i_fft_data_tready;
    assign o_fft_data_tvalid = in_load & i_aclken & i_src_tvalid;
    assign o_fft_data_tdata  = i_src_tdata;
    assign o_fft_data_tlast  = in_load & last_smp;
    assign src_hs            = o_src_tready & i_src_tvalid;

    always_comb begin
        cfg_word              = '0;
        cfg_word[CFG_INV_BIT] = i_inv;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (i_start) state_d = CFG;
            CFG:      state_d = LOAD;
            LOAD:     if (src_hs && last_smp) state_d = WAIT_OUT;
            WAIT_OUT: begin
                if (out_last) begin
                    state_d = DONE;
                end else if (wd_expire) begin
                    state_d = IDLE;
                end
            end
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            state_q          <= IDLE;
            o_busy           <= 1'b0;
            o_done           <= 1'b0;
            o_err            <= 1'b0;
            o_fft_cfg_tvalid <= 1'b0;
            o_fft_cfg_tdata  <= '0;
            o_frame_cnt      <= '0;
            o_alm_sticky     <= '0;
            smp_cnt_q        <= '0;
        end else if (i_aclken) begin
            state_q          <= state_d;
            o_busy           <= (state_d != IDLE);
            o_done           <= (state_d == DONE);
            o_fft_cfg_tvalid <= (state_d == CFG);
            o_err            <= in_wait & wd_expire & ~out_last;

            if (accept) begin
                o_fft_cfg_tdata <= cfg_word;
            end

            if (state_q == CFG) begin
                smp_cnt_q <= '0;
            end else if (src_hs) begin
                smp_cnt_q <= smp_cnt_q + SMP_ONE;
            end

            // Count lands together with the o_done pulse.
            if (in_wait && out_last) begin
                o_frame_cnt <= o_frame_cnt + 16'd1;
            end

            if (state_q == IDLE) begin
                if (i_start) begin
                    o_alm_sticky <= '0;
                end
            end else begin
                o_alm_sticky <= o_alm_sticky | i_fft_alm;
            end
        end
    end

    fft_ctrl_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .i_aclk    (i_aclk),
        .i_aresetn (i_aresetn),
        .i_aclken  (i_aclken),
        .i_run     (in_wait),
        .o_expire  (wd_expire)
    );

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl with a small
// stream monitor and hand-computed expectations.
module tb_fft_frame_ctrl;

    localparam int N   = 2048;
    localparam int TMO = 100;

    logic        i_aclk = 1'b0;
    logic        i_aresetn;
    logic        i_aclken;
    logic        i_start;
    logic        i_inv;
    logic        o_busy;
    logic        o_done;
    logic        o_err;
    logic        i_src_tvalid;
    logic [31:0] i_src_tdata;
    logic        o_src_tready;
    logic        o_fft_cfg_tvalid;
    logic [7:0]  o_fft_cfg_tdata;
    logic        o_fft_data_tvalid;
    logic [31:0] o_fft_data_tdata;
    logic        o_fft_data_tlast;
    logic        i_fft_data_tready;
    logic        i_fft_out_tvalid;
    logic        i_fft_out_tlast;
    logic [2:0]  i_fft_alm;
    logic [15:0] o_frame_cnt;
    logic [2:0]  o_alm_sticky;

    int n_chk;
    int n_fail;
    int hs_cnt;
    int tlast_cnt;
    int last_idx;
    int order_err;
    int src_idx;
    int cfg_cnt;
    int done_cnt;
    int err_cnt;
    bit gaps;

    always #5 i_aclk = ~i_aclk;

    fft_frame_ctrl #(
        .LOG2_FFT_LEN (11),
        .DATA_WIDTH   (32),
        .TIMEOUT      (TMO)
    ) dut (
        .i_aclk            (i_aclk),
        .i_aresetn         (i_aresetn),
        .i_aclken          (i_aclken),
        .i_start           (i_start),
        .i_inv             (i_inv),
        .o_busy            (o_busy),
        .o_done            (o_done),
        .o_err             (o_err),
        .i_src_tvalid      (i_src_tvalid),
        .i_src_tdata       (i_src_tdata),
        .o_src_tready      (o_src_tready),
        .o_fft_cfg_tvalid  (o_fft_cfg_tvalid),
        .o_fft_cfg_tdata   (o_fft_cfg_tdata),
        .o_fft_data_tvalid (o_fft_data_tvalid),
        .o_fft_data_tdata  (o_fft_data_tdata),
        .o_fft_data_tlast  (o_fft_data_tlast),
        .i_fft_data_tready (i_fft_data_tready),
        .i_fft_out_tvalid  (i_fft_out_tvalid),
        .i_fft_out_tlast   (i_fft_out_tlast),
        .i_fft_alm         (i_fft_alm),
        .o_frame_cnt       (o_frame_cnt),
        .o_alm_sticky      (o_alm_sticky)
    );

    function automatic logic [31:0] pat(input int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'h0F0F_1234;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] want);
        n_chk++;
        if (obs !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, want);
        end
    endtask

    // Observe the beat about to be taken, then cross one edge.
    task automatic tick;
        logic hs;
        #2;
        hs = o_src_tready & i_src_tvalid;
        if (hs) begin
            if (o_fft_data_tvalid !== 1'b1 ||
                o_fft_data_tdata !== pat(hs_cnt)) order_err++;
            hs_cnt++;
            if (o_fft_data_tlast === 1'b1) begin
                tlast_cnt++;
                last_idx = hs_cnt;
            end
        end
        if (o_fft_cfg_tvalid === 1'b1) cfg_cnt++;
        if (o_done === 1'b1) done_cnt++;
        if (o_err === 1'b1) err_cnt++;
        @(posedge i_aclk);
        #1;
        if (hs) src_idx++;
        if (!i_src_tvalid || hs)
            i_src_tvalid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        i_fft_data_tready = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        i_src_tdata = pat(src_idx);
    endtask

    task automatic start_frame(input logic inv);
        hs_cnt      = 0;
        tlast_cnt   = 0;
        last_idx    = 0;
        order_err   = 0;
        src_idx     = 0;
        cfg_cnt     = 0;
        i_src_tdata = pat(0);
        i_inv       = inv;
        i_start     = 1'b1;
        tick;
        i_start     = 1'b0;
        i_inv       = 1'b0;
    endtask

    task automatic run_load(input int pause_at, input int alm_at,
                            input int stray_at);
        int guard = 0;
        bit alm_f = 0;
        bit pause_f = 0;
        int hs_b;
        while (hs_cnt < N && guard < 30000) begin
            i_start = (stray_at >= 0) && (hs_cnt >= stray_at) &&
                      (hs_cnt < stray_at + 4);
            if (hs_cnt == alm_at && !alm_f) begin
                i_fft_alm = 3'b010;
                alm_f = 1;
            end else begin
                i_fft_alm = 3'b000;
            end
            if (hs_cnt == pause_at && !pause_f) begin
                pause_f  = 1;
                hs_b     = hs_cnt;
                i_aclken = 1'b0;
                repeat (10) tick;
                check("pause_hs", hs_cnt, hs_b);
                check("pause_busy", o_busy, 1);
                check("pause_tlast", o_fft_data_tlast, 0);
                check("pause_cnt", o_frame_cnt, 0);
                i_aclken = 1'b1;
            end
            tick;
            guard++;
        end
        i_start   = 1'b0;
        i_fft_alm = 3'b000;
    endtask

    task automatic load_checks(input string tag);
        check({tag, "_hs"}, hs_cnt, N);
        check({tag, "_tlast"}, tlast_cnt, 1);
        check({tag, "_lastidx"}, last_idx, N);
        check({tag, "_order"}, order_err, 0);
        check({tag, "_cfg"}, cfg_cnt, 1);
        check({tag, "_busy"}, o_busy, 1);
    endtask

    task automatic finish_out(input string tag, input int cnt);
        i_fft_out_tvalid = 1'b1;
        i_fft_out_tlast  = 1'b1;
        tick;
        i_fft_out_tvalid = 1'b0;
        i_fft_out_tlast  = 1'b0;
        check({tag, "_done"}, o_done, 1);
        check({tag, "_noerr"}, o_err, 0);
        check({tag, "_fcnt"}, o_frame_cnt, cnt);
        tick;
        check({tag, "_done_pulse"}, o_done, 0);
        check({tag, "_idle"}, o_busy, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int n;
        int d_b;
        int e_b;
        n_chk = 0;
        n_fail = 0;
        done_cnt = 0;
        err_cnt = 0;
        hs_cnt = 0;
        src_idx = 0;
        gaps = 0;
        i_aresetn = 1'b0;
        i_aclken = 1'b1;
        i_start = 1'b0;
        i_inv = 1'b0;
        i_src_tvalid = 1'b0;
        i_src_tdata = '0;
        i_fft_data_tready = 1'b1;
        i_fft_out_tvalid = 1'b0;
        i_fft_out_tlast = 1'b0;
        i_fft_alm = 3'b000;
        repeat (3) @(posedge i_aclk);
        #1;
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_err", o_err, 0);
        check("rst_cfgv", o_fft_cfg_tvalid, 0);
        check("rst_cfgd", o_fft_cfg_tdata, 0);
        check("rst_fcnt", o_frame_cnt, 0);
        check("rst_alm", o_alm_sticky, 0);
        check("rst_tlast", o_fft_data_tlast, 0);
        i_aresetn = 1'b1;
        tick;
        check("idle_tready", o_src_tready, 0);
        check("idle_tvalid", o_fft_data_tvalid, 0);

        // Frame 1: inverse, continuous stream.
        start_frame(1'b1);
        check("f1_cfgv", o_fft_cfg_tvalid, 1);
        check("f1_cfgd", o_fft_cfg_tdata, 8'h01);
        check("f1_busy0", o_busy, 1);
        tick;
        check("f1_cfg_pulse", o_fft_cfg_tvalid, 0);
        run_load(-1, -1, -1);
        load_checks("f1");
        d_b = done_cnt;
        i_fft_out_tvalid = 1'b1;
        repeat (3) tick;
        i_fft_out_tvalid = 1'b0;
        check("f1_notlast", done_cnt, d_b);
        finish_out("f1", 1);

        // Frame 2: forward, 50% gaps, stray start pulses.
        gaps = 1;
        start_frame(1'b0);
        check("f2_cfgd", o_fft_cfg_tdata, 8'h00);
        run_load(-1, -1, 500);
        gaps = 0;
        load_checks("f2");
        finish_out("f2", 2);

        // Frame 3: no output tlast, watchdog fires.
        e_b = err_cnt;
        start_frame(1'b1);
        run_load(-1, -1, -1);
        load_checks("f3");
        n = 0;
        do begin
            tick;
            n++;
        end while (o_err !== 1'b1 && n < 300);
        check("tmo_cycles", n, TMO);
        check("tmo_idle", o_busy, 0);
        check("tmo_fcnt", o_frame_cnt, 2);
        tick;
        check("tmo_pulse", o_err, 0);
        check("tmo_once", err_cnt - e_b, 1);

        // Frame 3b: tlast on the timeout cycle wins.
        start_frame(1'b0);
        run_load(-1, -1, -1);
        repeat (TMO - 1) tick;
        check("tie_busy", o_busy, 1);
        finish_out("tie", 3);

        // Frame 4: one alarm beat during load.
        start_frame(1'b0);
        run_load(-1, 700, -1);
        load_checks("f4");
        check("alm_load", o_alm_sticky, 3'b010);
        finish_out("f4", 4);
        i_fft_alm = 3'b100;
        tick;
        i_fft_alm = 3'b000;
        check("alm_idle", o_alm_sticky, 3'b010);

        // Frame 5: cleared on start, abandoned by reset.
        start_frame(1'b1);
        check("alm_clr", o_alm_sticky, 0);
        n = 0;
        while (hs_cnt < 1000 && n < 5000) begin
            tick;
            n++;
        end
        check("f5_hs", hs_cnt, 1000);
        d_b = done_cnt;
        e_b = err_cnt;
        i_aresetn = 1'b0;
        #1;
        check("mid_busy", o_busy, 0);
        check("mid_fcnt", o_frame_cnt, 0);
        check("mid_cfgd", o_fft_cfg_tdata, 0);
        check("mid_tready", o_src_tready, 0);
        repeat (2) tick;
        i_aresetn = 1'b1;
        tick;
        check("mid_nodone", done_cnt, d_b);
        check("mid_noerr", err_cnt, e_b);

        // Frame 6: fresh frame with a 10-cycle enable drop.
        start_frame(1'b1);
        run_load(1000, -1, -1);
        load_checks("f6");
        finish_out("f6", 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
